// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: shared counter, per-channel compare outputs,
// double-buffered period/compare, up, down and centre-aligned modes.
module pwm_timer_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                control,
  input  logic [WIDTH-1:0]          max_count,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [WIDTH-1:0]          count,
  output logic                      dir,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       signal
);

  typedef enum logic [1:0] {
    STOP = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    UPDN = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t                      mode;
  logic [WIDTH-1:0]           max_act;
  logic [WIDTH-1:0]           max_nxt;
  logic [WIDTH-1:0]           cnt_nxt;
  logic [CHANNELS*WIDTH-1:0]  cmp_act;
  logic [CHANNELS*WIDTH-1:0]  cmp_nxt;
  logic [CHANNELS-1:0]        raw;
  logic                       dir_nxt;
  logic                       bnd;
  logic                       xfer;
  logic                       pending;

  assign mode = mode_t'(control);

  always_comb begin
    cnt_nxt = count;
    dir_nxt = dir;
    bnd     = 1'b0;
    unique case (mode)
      STOP: ;
      UP: begin
        dir_nxt = 1'b0;
        if (count >= max_act) begin
          cnt_nxt = '0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = count + ONE;
        end
      end
      DOWN: begin
        dir_nxt = 1'b1;
        // reload uses the period that becomes active on this edge
        if (count == '0) begin
          cnt_nxt = (pending || load) ? max_count : max_act;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = count - ONE;
        end
      end
      UPDN: begin
        if (!dir) begin
          if (count >= max_act) begin
            if (max_act == '0) begin
              cnt_nxt = '0;
              bnd     = 1'b1;
            end else begin
              cnt_nxt = max_act - ONE;
              dir_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = count + ONE;
          end
        end else if (count <= ONE) begin
          cnt_nxt = '0;
          dir_nxt = 1'b0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = count - ONE;
        end
      end
      default: ;
    endcase
  end

  assign xfer    = bnd && (pending || load);
  assign max_nxt = xfer ? max_count : max_act;
  assign cmp_nxt = xfer ? compare : cmp_act;

  // compare against the next count so outputs line up with count
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign raw[i] = cnt_nxt < cmp_nxt[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      dir        <= 1'b0;
      period_end <= 1'b0;
      pending    <= 1'b0;
      max_act    <= max_count;
      cmp_act    <= compare;
      signal     <= polarity;
    end else begin
      count      <= cnt_nxt;
      dir        <= dir_nxt;
      period_end <= bnd;
      pending    <= xfer ? 1'b0 : (pending | load);
      max_act    <= max_nxt;
      cmp_act    <= cmp_nxt;
      signal     <= raw ^ polarity;
    end
  end

endmodule
